// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
//
// Accepts a valid/ready byte stream framed as LEN_LO, LEN_HI (16-bit word
// count N) followed by 4*N data bytes, least-significant byte first within
// each word. Every assembled word is written to a word-addressed memory
// port with a single-cycle strobe. The CPU is held in reset until the whole
// image has been loaded; a malformed frame parks the loader in an error
// state with the CPU still held.
//
// Build option: define IMEM_LOADER_CSUM_EN to expect one trailing byte equal
// to the XOR of all data bytes. A mismatch ends in the error state (words
// already written are left in memory). Without the macro the last word (or
// an empty frame) completes the load directly.
module imem_loader #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic [3:0]    mem_be,
  output logic          mem_wren,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  // Number of words the target memory can hold.
  localparam int unsigned DEPTH = 32'd1 << AW;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e        state_q;

  // Registered outputs.
  logic          s_ready_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_din_q;
  logic [3:0]    mem_be_q;
  logic          mem_wren_q;
  logic          cpu_rst_q;
  logic          done_q;
  logic          err_q;

  // Frame bookkeeping. The word counter is one bit wider than the 16-bit
  // length so that it can hold the full count without aliasing.
  logic [15:0]   len_q;
  logic [1:0]    byte_cnt_q;
  logic [16:0]   wcnt_q;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    csum_q;
  logic [7:0]    csum_d;
`endif

  // Next-value helpers shared by several FSM branches.
  logic          accept;
  logic [15:0]   len_d;
  logic          len_too_big;
  logic          len_zero;
  logic [31:0]   din_d;
  logic [1:0]    byte_cnt_d;
  logic [16:0]   wcnt_d;
  logic          last_word;
  logic [AW-1:0] addr_d;

  // Handshake, length decode and counter increments.
  always_comb begin
    accept      = s_valid && s_ready_q;
    len_d       = {s_data, len_q[7:0]};
    len_too_big = (32'(len_d) > DEPTH);
    len_zero    = (len_d == 16'd0);
    byte_cnt_d  = byte_cnt_q + 2'd1;
    wcnt_d      = wcnt_q + 17'd1;
    last_word   = (wcnt_d == {1'b0, len_q});
    // The address register holds at the top of memory instead of wrapping,
    // so a full-depth image leaves it at DEPTH-1.
    addr_d      = (&mem_addr_q) ? mem_addr_q : mem_addr_q + 1'b1;
  end

  // Little-endian byte lane insertion into the word being assembled.
  always_comb begin
    din_d = mem_din_q;
    din_d[8*byte_cnt_q +: 8] = s_data;
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running XOR over every accepted data byte.
  always_comb begin
    csum_d = csum_q ^ s_data;
  end
`endif

  // Load sequencer: single FSM owning the state and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN0;
      s_ready_q  <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_be_q   <= 4'h0;
      mem_wren_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      wcnt_q     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_LEN0: begin
          if (accept) begin
            len_q[7:0] <= s_data;
            state_q    <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (accept) begin
            len_q <= len_d;
            if (len_too_big) begin
              // Oversized image is refused before anything is written.
              state_q   <= S_ERR;
              s_ready_q <= 1'b0;
              err_q     <= 1'b1;
            end else if (len_zero) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q   <= S_CSUM;
`else
              state_q   <= S_DONE;
              s_ready_q <= 1'b0;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
`endif
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            mem_din_q  <= din_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
            if (byte_cnt_q == 2'd3) begin
              // Word complete: strobe it out next cycle and pause the stream.
              state_q    <= S_WRITE;
              s_ready_q  <= 1'b0;
              mem_wren_q <= 1'b1;
              mem_be_q   <= 4'hF;
            end
          end
        end

        S_WRITE: begin
          mem_wren_q <= 1'b0;
          mem_be_q   <= 4'h0;
          mem_addr_q <= addr_d;
          wcnt_q     <= wcnt_d;
          if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_q   <= S_CSUM;
            s_ready_q <= 1'b1;
`else
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b0;
`endif
          end else begin
            state_q   <= S_DATA;
            s_ready_q <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          if (accept) begin
            s_ready_q <= 1'b0;
            if (s_data == csum_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          s_ready_q <= 1'b0;
        end

        S_ERR: begin
          s_ready_q  <= 1'b0;
          mem_wren_q <= 1'b0;
          cpu_rst_q  <= 1'b1;
        end

        default: begin
          // Unreachable encodings fail safe with the CPU held in reset.
          state_q    <= S_ERR;
          s_ready_q  <= 1'b0;
          mem_wren_q <= 1'b0;
          mem_be_q   <= 4'h0;
          cpu_rst_q  <= 1'b1;
          err_q      <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_be   = mem_be_q;
  assign mem_wren = mem_wren_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (AW=10). Frames are driven through the byte
// stream with configurable idle gaps; a reference model derives the expected
// memory writes and final status from the frame contents alone.
module tb_imem_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [3:0]    mem_be;
  logic          mem_wren;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  // Observed writes and protocol violations.
  logic [AW-1:0] act_addr[$];
  logic [31:0]   act_data[$];
  int            be_bad  = 0;
  int            coh_bad = 0;

  // Reference model results.
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic          exp_done;
  logic          exp_err;
  int            exp_nbytes;

  imem_loader #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_be   (mem_be),
    .mem_wren (mem_wren),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_din);
      if (mem_be !== 4'hF) be_bad++;
    end
    if (!rst && (cpu_rst === done)) coh_bad++;
  end

  // XOR of the data bytes of a frame with length field n.
  function automatic logic [7:0] xor_data(input bq_t b, input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x ^= b[2 + i];
    return x;
  endfunction

  // Reference model: what a loader must do with frame b.
  task automatic model(input bq_t b);
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = int'(b[0]) + 256 * int'(b[1]);
    if (n > DEPTH) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_nbytes = 2;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(AW'(w));
      exp_data.push_back({b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]});
    end
`ifdef IMEM_LOADER_CSUM_EN
    exp_nbytes = 2 + 4 * n + 1;
    exp_done = (b[exp_nbytes-1] == xor_data(b, n));
    exp_err  = !exp_done;
`else
    exp_nbytes = 2 + 4 * n;
    exp_done = 1'b1;
    exp_err  = 1'b0;
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    act_addr.delete();
    act_data.delete();
    be_bad = 0;
    coh_bad = 0;
  endtask

  // Offer bytes b[from..to-1]; each is preceded by a random idle gap.
  // Returns at 1 time unit after the edge that accepted the last byte.
  task automatic drive_bytes(input bq_t b, input int from, input int to,
                             input int mingap, input int maxgap,
                             inout int timeouts);
    int gap;
    bit got;
    for (int i = from; i < to; i++) begin
      gap = (maxgap > mingap) ? int'($urandom_range(maxgap, mingap)) : mingap;
      repeat (gap) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = b[i];
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        if (s_ready === 1'b1) got = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!got) timeouts++;
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_end(inout int timeouts);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (done === 1'b1 || err === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) timeouts++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_din !== 32'h0) begin failures++; $display("FAIL reset_mem_din got=%h exp=0", mem_din); end
    checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_be got=%h exp=0", mem_be); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL reset_mem_wren got=%b exp=0", mem_wren); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_empty_frame();
    bq_t b;
    int to = 0;
    logic [31:0] din_before;
    b = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
    b.push_back(8'h00);
`endif
    reset_dut();
    drive_bytes(b, 0, b.size(), 0, 0, to);
    wait_end(to);
    checks++; if (to !== 0) begin failures++; $display("FAIL empty_timeout got=%0d exp=0", to); end
    checks++; if (act_data.size() !== 0) begin failures++; $display("FAIL empty_writes got=%0d exp=0", act_data.size()); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL empty_done got=%b exp=1", done); end
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL empty_cpu_rst got=%b exp=0", cpu_rst); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL empty_err got=%b exp=0", err); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL empty_s_ready got=%b exp=0", s_ready); end
    // Bytes offered after completion must be ignored.
    din_before = mem_din;
    s_valid = 1'b1; s_data = 8'hA5;
    repeat (6) @(posedge clk);
    #1;
    s_valid = 1'b0;
    checks++; if (mem_din !== din_before || act_data.size() !== 0 || done !== 1'b1)
      begin failures++; $display("FAIL empty_ignore din=%h writes=%0d done=%b exp din=%h writes=0 done=1", mem_din, act_data.size(), done, din_before); end
  endtask

  function automatic bq_t two_word_frame();
    bq_t b;
    b = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h0A, 8'h00, 8'h09, 8'h20};
`ifdef IMEM_LOADER_CSUM_EN
    b.push_back(xor_data(b, 2));
`endif
    return b;
  endfunction

  task automatic test_two_words();
    bq_t b;
    int to = 0;
    b = two_word_frame();
    reset_dut();
    drive_bytes(b, 0, 6, 0, 0, to);
    // First word strobes in the cycle right after its 4th byte.
    checks++; if (mem_wren !== 1'b1 || mem_addr !== 10'd0 || mem_din !== 32'h20080005)
      begin failures++; $display("FAIL two_latency wren=%b addr=%0d din=%h exp wren=1 addr=0 din=20080005", mem_wren, mem_addr, mem_din); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL two_ready_in_write got=%b exp=0", s_ready); end
    drive_bytes(b, 6, b.size(), 0, 0, to);
    wait_end(to);
    checks++; if (to !== 0) begin failures++; $display("FAIL two_timeout got=%0d exp=0", to); end
    checks++; if (act_data.size() !== 2) begin failures++; $display("FAIL two_wr_count got=%0d exp=2", act_data.size()); end
    if (act_data.size() == 2) begin
      checks++; if (act_addr[0] !== 10'd0 || act_data[0] !== 32'h20080005)
        begin failures++; $display("FAIL two_word0 got=[%0d]=%h exp=[0]=20080005", act_addr[0], act_data[0]); end
      checks++; if (act_addr[1] !== 10'd1 || act_data[1] !== 32'h2009000A)
        begin failures++; $display("FAIL two_word1 got=[%0d]=%h exp=[1]=2009000a", act_addr[1], act_data[1]); end
    end
    checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0)
      begin failures++; $display("FAIL two_status done=%b err=%b cpu_rst=%b exp 1 0 0", done, err, cpu_rst); end
    checks++; if (be_bad !== 0 || coh_bad !== 0)
      begin failures++; $display("FAIL two_protocol be_bad=%0d coh_bad=%0d exp 0 0", be_bad, coh_bad); end
  endtask

  task automatic test_stalls();
    bq_t b;
    int to = 0;
    b = two_word_frame();
    model(b);
    for (int rep = 0; rep < 3; rep++) begin
      reset_dut();
      // Alternate-cycle valid, then random stalls of up to 6 cycles.
      drive_bytes(b, 0, b.size(), 1, (rep == 0) ? 1 : 6, to);
      wait_end(to);
      checks++; if (act_data.size() !== exp_data.size())
        begin failures++; $display("FAIL stall_wr_count rep=%0d got=%0d exp=%0d", rep, act_data.size(), exp_data.size()); end
      for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
        checks++; if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i])
          begin failures++; $display("FAIL stall_word rep=%0d i=%0d got=[%0d]=%h exp=[%0d]=%h", rep, i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]); end
      end
      checks++; if (done !== exp_done || err !== exp_err)
        begin failures++; $display("FAIL stall_status rep=%0d done=%b err=%b exp %b %b", rep, done, err, exp_done, exp_err); end
    end
    checks++; if (to !== 0) begin failures++; $display("FAIL stall_timeout got=%0d exp=0", to); end
  endtask

  task automatic test_overflow();
    bq_t b;
    int to = 0;
    logic [15:0] lens[2];
    lens[0] = 16'h0401;
    lens[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      b = '{lens[k][7:0], lens[k][15:8], 8'h11, 8'h22, 8'h33, 8'h44};
      reset_dut();
      drive_bytes(b, 0, 2, 0, 0, to);
      wait_end(to);
      // Further bytes are refused in the error state.
      s_valid = 1'b1; s_data = 8'h11;
      repeat (8) @(posedge clk);
      #1;
      s_valid = 1'b0;
      checks++; if (err !== 1'b1 || cpu_rst !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0)
        begin failures++; $display("FAIL ovf_status len=%h err=%b cpu_rst=%b s_ready=%b done=%b exp 1 1 0 0", lens[k], err, cpu_rst, s_ready, done); end
      checks++; if (act_data.size() !== 0)
        begin failures++; $display("FAIL ovf_writes len=%h got=%0d exp=0", lens[k], act_data.size()); end
    end
    checks++; if (to !== 0) begin failures++; $display("FAIL ovf_timeout got=%0d exp=0", to); end
  endtask

  task automatic test_full_depth();
    bq_t b;
    int to = 0;
    int errs = 0;
    b = '{8'(DEPTH % 256), 8'(DEPTH / 256)};
    for (int i = 0; i < 4 * DEPTH; i++) b.push_back(8'($urandom));
`ifdef IMEM_LOADER_CSUM_EN
    b.push_back(xor_data(b, DEPTH));
`endif
    model(b);
    reset_dut();
    drive_bytes(b, 0, exp_nbytes, 0, 0, to);
    wait_end(to);
    checks++; if (to !== 0) begin failures++; $display("FAIL full_timeout got=%0d exp=0", to); end
    checks++; if (act_data.size() !== DEPTH)
      begin failures++; $display("FAIL full_wr_count got=%0d exp=%0d", act_data.size(), DEPTH); end
    for (int i = 0; i < exp_data.size() && i < act_data.size(); i++)
      if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i]) errs++;
    checks++; if (errs !== 0) begin failures++; $display("FAIL full_words bad=%0d exp=0", errs); end
    if (act_addr.size() == DEPTH) begin
      checks++; if (act_addr[DEPTH-1] !== AW'(DEPTH - 1))
        begin failures++; $display("FAIL full_last_addr got=%0d exp=%0d", act_addr[DEPTH-1], DEPTH - 1); end
    end
    checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0)
      begin failures++; $display("FAIL full_status done=%b err=%b cpu_rst=%b exp 1 0 0", done, err, cpu_rst); end
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_checksum_bad();
    bq_t b;
    int to = 0;
    b = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    reset_dut();
    drive_bytes(b, 0, b.size(), 0, 2, to);
    wait_end(to);
    checks++; if (to !== 0) begin failures++; $display("FAIL csum_timeout got=%0d exp=0", to); end
    checks++; if (act_data.size() !== 1)
      begin failures++; $display("FAIL csum_wr_count got=%0d exp=1", act_data.size()); end
    if (act_data.size() == 1) begin
      checks++; if (act_addr[0] !== 10'd0 || act_data[0] !== 32'h04030201)
        begin failures++; $display("FAIL csum_word got=[%0d]=%h exp=[0]=04030201", act_addr[0], act_data[0]); end
    end
    checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1)
      begin failures++; $display("FAIL csum_status err=%b done=%b cpu_rst=%b exp 1 0 1", err, done, cpu_rst); end
  endtask
`endif

  task automatic test_mid_reset();
    bq_t b;
    int to = 0;
    b = two_word_frame();
    reset_dut();
    drive_bytes(b, 0, 5, 0, 0, to);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (act_data.size() !== 0)
      begin failures++; $display("FAIL midrst_writes got=%0d exp=0", act_data.size()); end
    checks++; if (s_ready !== 1'b1 || mem_din !== 32'h0 || mem_addr !== '0)
      begin failures++; $display("FAIL midrst_state s_ready=%b din=%h addr=%0d exp 1 0 0", s_ready, mem_din, mem_addr); end
    // Replay the full frame without another reset.
    model(b);
    drive_bytes(b, 0, b.size(), 0, 3, to);
    wait_end(to);
    checks++; if (to !== 0) begin failures++; $display("FAIL midrst_timeout got=%0d exp=0", to); end
    checks++; if (act_data.size() !== exp_data.size())
      begin failures++; $display("FAIL midrst_wr_count got=%0d exp=%0d", act_data.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
      checks++; if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i])
        begin failures++; $display("FAIL midrst_word i=%0d got=[%0d]=%h exp=[%0d]=%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]); end
    end
    checks++; if (done !== 1'b1 || err !== 1'b0)
      begin failures++; $display("FAIL midrst_status done=%b err=%b exp 1 0", done, err); end
  endtask

  task automatic test_random();
    bq_t b;
    int to;
    int n;
    int kind;
    for (int it = 0; it < 12; it++) begin
      to = 0;
      kind = int'($urandom_range(9, 0));
      if (kind == 0) n = 0;
      else if (kind == 1) n = int'($urandom_range(65535, DEPTH + 1));
      else n = int'($urandom_range(12, 1));
      b = '{8'(n % 256), 8'(n / 256)};
      if (n <= DEPTH) begin
        for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
`ifdef IMEM_LOADER_CSUM_EN
        b.push_back(($urandom_range(1, 0) == 1) ? xor_data(b, n) : ~xor_data(b, n));
`endif
      end
      model(b);
      reset_dut();
      drive_bytes(b, 0, exp_nbytes, 0, int'($urandom_range(4, 0)), to);
      wait_end(to);
      checks++; if (to !== 0) begin failures++; $display("FAIL rand_timeout it=%0d n=%0d got=%0d exp=0", it, n, to); end
      checks++; if (act_data.size() !== exp_data.size())
        begin failures++; $display("FAIL rand_wr_count it=%0d n=%0d got=%0d exp=%0d", it, n, act_data.size(), exp_data.size()); end
      for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
        checks++; if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i])
          begin failures++; $display("FAIL rand_word it=%0d i=%0d got=[%0d]=%h exp=[%0d]=%h", it, i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]); end
      end
      checks++; if (done !== exp_done || err !== exp_err || cpu_rst !== !exp_done)
        begin failures++; $display("FAIL rand_status it=%0d done=%b err=%b cpu_rst=%b exp %b %b %b", it, done, err, cpu_rst, exp_done, exp_err, !exp_done); end
      checks++; if (be_bad !== 0 || coh_bad !== 0)
        begin failures++; $display("FAIL rand_protocol it=%0d be_bad=%0d coh_bad=%0d exp 0 0", it, be_bad, coh_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_two_words();
    test_stalls();
    test_overflow();
    test_full_depth();
`ifdef IMEM_LOADER_CSUM_EN
    test_checksum_bad();
`endif
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout sim_time=%0t limit=900000", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
